// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode between fetch and execute.
//
// Purpose
//   Takes one instruction per cycle from fetch, reads operands from the
//   register file and substitutes the same-cycle write-back value where it
//   is newer. Decodes opcode/funct3/funct7 into ALU and memory controls and
//   a sign-extended immediate. Inserts one bubble on a load-use hazard.
//   Results are held in an ID/EX register with a valid/ready handshake.
//
// Ports
//   clock, reset (async, active-low)
//   if_valid / if_ready / if_instruction / if_pc   fetch side handshake
//   read_register_1/2 -> read_data_1/2            register file (combinational)
//   wb_register_write / wb_write_register / wb_write_data   write-back bypass
//   flush                                          drop held and incoming instruction
//   ex_ready                                       execute accepts the held instruction
//   id_*                                           ID/EX register contents
module decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instruction,
    input  logic [31:0] if_pc,
    output logic [4:0]  read_register_1,
    output logic [4:0]  read_register_2,
    input  logic [31:0] read_data_1,
    input  logic [31:0] read_data_2,
    input  logic        wb_register_write,
    input  logic [4:0]  wb_write_register,
    input  logic [31:0] wb_write_data,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_rs1_data,
    output logic [31:0] id_rs2_data,
    output logic [31:0] id_immediate,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [3:0]  id_alu_op,
    output logic        id_alu_src_imm,
    output logic        id_alu_src_pc,
    output logic        id_register_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_branch,
    output logic        id_jump,
    output logic [2:0]  id_funct3,
    output logic        id_illegal
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } imm_fmt_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    alu_op_t     base_op;
    alu_op_t     dec_alu_op;
    imm_fmt_t    imm_fmt;
    logic [31:0] imm_value;
    logic        dec_src_imm, dec_src_pc, dec_register_write, dec_mem_read;
    logic        dec_mem_write, dec_branch, dec_jump, dec_illegal;
    logic        use_rs1, use_rs2, has_rd;
    logic        hazard, advance;
    logic [31:0] rs1_value, rs2_value;

    assign opcode          = if_instruction[6:0];
    assign funct3          = if_instruction[14:12];
    assign funct7          = if_instruction[31:25];
    assign read_register_1 = if_instruction[19:15];
    assign read_register_2 = if_instruction[24:20];

    // ALU operation shared by register and immediate arithmetic forms.
    always_comb begin
        base_op = ALU_ADD;
        case (funct3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    end

    // Main opcode decode. Operand usage flags stay set for bad funct
    // encodings so the hazard check remains conservative.
    always_comb begin
        imm_fmt            = FMT_R;
        dec_alu_op         = ALU_ADD;
        dec_src_imm        = 1'b0;
        dec_src_pc         = 1'b0;
        dec_register_write = 1'b0;
        dec_mem_read       = 1'b0;
        dec_mem_write      = 1'b0;
        dec_branch         = 1'b0;
        dec_jump           = 1'b0;
        dec_illegal        = 1'b0;
        use_rs1            = 1'b0;
        use_rs2            = 1'b0;
        has_rd             = 1'b1;
        case (opcode)
            OP_REG: begin
                use_rs1            = 1'b1;
                use_rs2            = 1'b1;
                dec_register_write = 1'b1;
                if (funct7 == 7'h00)
                    dec_alu_op = base_op;
                else if (funct7 == 7'h20 && funct3 == 3'b000)
                    dec_alu_op = ALU_SUB;
                else if (funct7 == 7'h20 && funct3 == 3'b101)
                    dec_alu_op = ALU_SRA;
                else
                    dec_illegal = 1'b1;
            end
            OP_IMM: begin
                imm_fmt            = FMT_I;
                use_rs1            = 1'b1;
                dec_register_write = 1'b1;
                dec_src_imm        = 1'b1;
                dec_alu_op         = base_op;
                // funct7 only carries meaning for the shift-immediate forms.
                if (funct3 == 3'b001 && funct7 != 7'h00)
                    dec_illegal = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == 7'h20)
                        dec_alu_op = ALU_SRA;
                    else if (funct7 != 7'h00)
                        dec_illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                imm_fmt            = FMT_I;
                use_rs1            = 1'b1;
                dec_register_write = 1'b1;
                dec_mem_read       = 1'b1;
                dec_src_imm        = 1'b1;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                    dec_illegal = 1'b1;
            end
            OP_STORE: begin
                imm_fmt       = FMT_S;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                has_rd        = 1'b0;
                dec_mem_write = 1'b1;
                dec_src_imm   = 1'b1;
                if (funct3 > 3'b010)
                    dec_illegal = 1'b1;
            end
            OP_BRANCH: begin
                imm_fmt    = FMT_B;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                has_rd     = 1'b0;
                dec_branch = 1'b1;
                dec_alu_op = ALU_SUB;
                if (funct3 == 3'b010 || funct3 == 3'b011)
                    dec_illegal = 1'b1;
            end
            OP_LUI: begin
                imm_fmt            = FMT_U;
                dec_register_write = 1'b1;
                dec_src_imm        = 1'b1;
                dec_alu_op         = ALU_PASS_B;
            end
            OP_AUIPC: begin
                imm_fmt            = FMT_U;
                dec_register_write = 1'b1;
                dec_src_imm        = 1'b1;
                dec_src_pc         = 1'b1;
            end
            OP_JAL: begin
                imm_fmt            = FMT_J;
                dec_register_write = 1'b1;
                dec_jump           = 1'b1;
                dec_src_imm        = 1'b1;
                dec_src_pc         = 1'b1;
            end
            OP_JALR: begin
                imm_fmt            = FMT_I;
                use_rs1            = 1'b1;
                dec_register_write = 1'b1;
                dec_jump           = 1'b1;
                dec_src_imm        = 1'b1;
                if (funct3 != 3'b000)
                    dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm_value = 32'd0;
        case (imm_fmt)
            FMT_I:   imm_value = {{20{if_instruction[31]}}, if_instruction[31:20]};
            FMT_S:   imm_value = {{20{if_instruction[31]}}, if_instruction[31:25],
                                  if_instruction[11:7]};
            FMT_B:   imm_value = {{19{if_instruction[31]}}, if_instruction[31],
                                  if_instruction[7], if_instruction[30:25],
                                  if_instruction[11:8], 1'b0};
            FMT_U:   imm_value = {if_instruction[31:12], 12'd0};
            FMT_J:   imm_value = {{11{if_instruction[31]}}, if_instruction[31],
                                  if_instruction[19:12], if_instruction[20],
                                  if_instruction[30:21], 1'b0};
            default: imm_value = 32'd0;
        endcase
    end

    // The register file only updates at the edge, so a write in flight this
    // cycle must override the stale read. x0 is hardwired to zero.
    always_comb begin
        rs1_value = read_data_1;
        rs2_value = read_data_2;
        if (read_register_1 == 5'd0)
            rs1_value = 32'd0;
        else if (wb_register_write && wb_write_register == read_register_1)
            rs1_value = wb_write_data;
        if (read_register_2 == 5'd0)
            rs2_value = 32'd0;
        else if (wb_register_write && wb_write_register == read_register_2)
            rs2_value = wb_write_data;
    end

    assign hazard = id_valid && id_mem_read && (id_rd != 5'd0) &&
                    ((use_rs1 && read_register_1 == id_rd) ||
                     (use_rs2 && read_register_2 == id_rd));
    assign advance  = !id_valid || ex_ready;
    assign if_ready = flush || (advance && !hazard);

    // ID/EX register. Flush only clears valid; the payload is ignored
    // downstream while valid is low. Illegal instructions carry no side
    // effects and a zero immediate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            id_valid          <= 1'b0;
            id_pc             <= 32'd0;
            id_rs1_data       <= 32'd0;
            id_rs2_data       <= 32'd0;
            id_immediate      <= 32'd0;
            id_rs1            <= 5'd0;
            id_rs2            <= 5'd0;
            id_rd             <= 5'd0;
            id_alu_op         <= 4'd0;
            id_alu_src_imm    <= 1'b0;
            id_alu_src_pc     <= 1'b0;
            id_register_write <= 1'b0;
            id_mem_read       <= 1'b0;
            id_mem_write      <= 1'b0;
            id_branch         <= 1'b0;
            id_jump           <= 1'b0;
            id_funct3         <= 3'd0;
            id_illegal        <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (advance) begin
            id_valid          <= if_valid && !hazard;
            id_pc             <= if_pc;
            id_rs1_data       <= rs1_value;
            id_rs2_data       <= rs2_value;
            id_immediate      <= dec_illegal ? 32'd0 : imm_value;
            id_rs1            <= read_register_1;
            id_rs2            <= read_register_2;
            id_rd             <= has_rd ? if_instruction[11:7] : 5'd0;
            id_alu_op         <= dec_illegal ? ALU_ADD : dec_alu_op;
            id_alu_src_imm    <= dec_src_imm && !dec_illegal;
            id_alu_src_pc     <= dec_src_pc && !dec_illegal;
            id_register_write <= dec_register_write && !dec_illegal;
            id_mem_read       <= dec_mem_read && !dec_illegal;
            id_mem_write      <= dec_mem_write && !dec_illegal;
            id_branch         <= dec_branch && !dec_illegal;
            id_jump           <= dec_jump && !dec_illegal;
            id_funct3         <= funct3;
            id_illegal        <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
//
// Purpose
//   Acts as fetch, register file, write-back and execute around the stage.
//   An instruction-level model predicts the ID/EX register and if_ready
//   every cycle; directed sequences pin the model with literal values,
//   followed by randomized traffic and a mid-cycle asynchronous reset.
module tb_decode_stage;

    logic        clock;
    logic        reset;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [4:0]  read_register_1, read_register_2;
    logic [31:0] read_data_1, read_data_2;
    logic        wb_register_write;
    logic [4:0]  wb_write_register;
    logic [31:0] wb_write_data;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_immediate;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src_imm, id_alu_src_pc, id_register_write;
    logic        id_mem_read, id_mem_write, id_branch, id_jump;
    logic [2:0]  id_funct3;
    logic        id_illegal;

    int checks = 0;
    int errors = 0;

    // Register file contents owned by the bench; writes land at the
    // following negedge, after the stage has sampled the old value.
    logic [31:0] rf [32];
    logic        pend_we;
    logic [4:0]  pend_rd;
    logic [31:0] pend_data;

    assign read_data_1 = rf[if_instruction[19:15]];
    assign read_data_2 = rf[if_instruction[24:20]];

    typedef struct packed {
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        simm, spc, regw, memr, memw, br, jmp, ill, u1, u2;
        logic [4:0]  rd;
    } dec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic        simm, spc, regw, memr, memw, br, jmp;
        logic [2:0]  f3;
        logic        ill;
    } idex_t;

    idex_t m;

    decode_stage dut (
        .clock(clock), .reset(reset),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instruction(if_instruction), .if_pc(if_pc),
        .read_register_1(read_register_1), .read_register_2(read_register_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .wb_register_write(wb_register_write), .wb_write_register(wb_write_register),
        .wb_write_data(wb_write_data),
        .flush(flush), .ex_ready(ex_ready),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_immediate(id_immediate),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_alu_src_imm(id_alu_src_imm),
        .id_alu_src_pc(id_alu_src_pc), .id_register_write(id_register_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jump(id_jump),
        .id_funct3(id_funct3), .id_illegal(id_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction-level decode: what each RV32I instruction means.
    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        logic [3:0] arith [8];
        logic [2:0] f3;
        logic [6:0] f7;
        arith = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        f3 = i[14:12];
        f7 = i[31:25];
        d = '0;
        d.rd = i[11:7];
        case (i[6:0])
            7'h33: begin
                d.u1 = 1; d.u2 = 1; d.regw = 1;
                if (f7 == 7'h00) d.alu = arith[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) d.alu = 4'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) d.alu = 4'd7;
                else d.ill = 1;
            end
            7'h13: begin
                d.u1 = 1; d.regw = 1; d.simm = 1;
                d.imm = {{20{i[31]}}, i[31:20]};
                d.alu = arith[f3];
                if (f3 == 3'd1 && f7 != 7'h00) d.ill = 1;
                if (f3 == 3'd5 && f7 == 7'h20) d.alu = 4'd7;
                if (f3 == 3'd5 && f7 != 7'h20 && f7 != 7'h00) d.ill = 1;
            end
            7'h03: begin
                d.u1 = 1; d.regw = 1; d.memr = 1; d.simm = 1;
                d.imm = {{20{i[31]}}, i[31:20]};
                d.ill = (f3 == 3'd3) || (f3 >= 3'd6);
            end
            7'h23: begin
                d.u1 = 1; d.u2 = 1; d.memw = 1; d.simm = 1; d.rd = 0;
                d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
                d.ill = f3 >= 3'd3;
            end
            7'h63: begin
                d.u1 = 1; d.u2 = 1; d.br = 1; d.alu = 4'd1; d.rd = 0;
                d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
                d.ill = (f3 == 3'd2) || (f3 == 3'd3);
            end
            7'h37: begin
                d.regw = 1; d.simm = 1; d.alu = 4'd10;
                d.imm = i & 32'hFFFFF000;
            end
            7'h17: begin
                d.regw = 1; d.simm = 1; d.spc = 1;
                d.imm = i & 32'hFFFFF000;
            end
            7'h6F: begin
                d.regw = 1; d.jmp = 1; d.simm = 1; d.spc = 1;
                d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            end
            7'h67: begin
                d.u1 = 1; d.regw = 1; d.jmp = 1; d.simm = 1;
                d.imm = {{20{i[31]}}, i[31:20]};
                d.ill = f3 != 3'd0;
            end
            default: d.ill = 1;
        endcase
        if (d.ill) begin
            d.imm = 0; d.alu = 0; d.simm = 0; d.spc = 0;
            d.regw = 0; d.memr = 0; d.memw = 0; d.br = 0; d.jmp = 0;
        end
        return d;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_register_write && wb_write_register == r) return wb_write_data;
        return rf[r];
    endfunction

    function automatic logic model_hazard();
        dec_t d;
        d = decode(if_instruction);
        return m.valid && m.memr && m.rd != 5'd0 &&
               ((d.u1 && if_instruction[19:15] == m.rd) ||
                (d.u2 && if_instruction[24:20] == m.rd));
    endfunction

    function automatic logic model_ready();
        return flush || ((!m.valid || ex_ready) && !model_hazard());
    endfunction

    task automatic model_step();
        dec_t  d;
        logic  hz;
        d  = decode(if_instruction);
        hz = model_hazard();
        if (flush) begin
            m.valid = 1'b0;
        end else if (!m.valid || ex_ready) begin
            m.valid = if_valid && !hz;
            m.pc    = if_pc;
            m.rs1   = if_instruction[19:15];
            m.rs2   = if_instruction[24:20];
            m.d1    = operand(m.rs1);
            m.d2    = operand(m.rs2);
            m.rd    = d.rd;
            m.imm   = d.imm;
            m.alu   = d.alu;
            m.simm  = d.simm;
            m.spc   = d.spc;
            m.regw  = d.regw;
            m.memr  = d.memr;
            m.memw  = d.memw;
            m.br    = d.br;
            m.jmp   = d.jmp;
            m.f3    = if_instruction[14:12];
            m.ill   = d.ill;
        end
    endtask

    task automatic check_output();
        check("id_valid", 32'(id_valid), 32'(m.valid));
        if (m.valid) begin
            check("id_pc", id_pc, m.pc);
            check("id_rs1_data", id_rs1_data, m.d1);
            check("id_rs2_data", id_rs2_data, m.d2);
            check("id_immediate", id_immediate, m.imm);
            check("id_rs1", 32'(id_rs1), 32'(m.rs1));
            check("id_rs2", 32'(id_rs2), 32'(m.rs2));
            check("id_rd", 32'(id_rd), 32'(m.rd));
            check("id_alu_op", 32'(id_alu_op), 32'(m.alu));
            check("id_funct3", 32'(id_funct3), 32'(m.f3));
            check("id_controls",
                  32'({id_alu_src_imm, id_alu_src_pc, id_register_write, id_mem_read,
                       id_mem_write, id_branch, id_jump, id_illegal}),
                  32'({m.simm, m.spc, m.regw, m.memr, m.memw, m.br, m.jmp, m.ill}));
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, let the
    // edge happen, then compare the ID/EX register against the model.
    task automatic apply_stimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                  input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                                  input logic fl, input logic exr, output logic rdy);
        @(negedge clock);
        if (pend_we && pend_rd != 5'd0) rf[pend_rd] = pend_data;
        pend_we           = 1'b0;
        if_valid          = v;
        if_instruction    = ins;
        if_pc             = pc;
        wb_register_write = we;
        wb_write_register = wrd;
        wb_write_data     = wd;
        flush             = fl;
        ex_ready          = exr;
        #1;
        rdy = if_ready;
        check("if_ready", 32'(if_ready), 32'(model_ready()));
        check("read_register_1", 32'(read_register_1), 32'(ins[19:15]));
        check("read_register_2", 32'(read_register_2), 32'(ins[24:20]));
        @(posedge clock);
        model_step();
        pend_we   = we;
        pend_rd   = wrd;
        pend_data = wd;
        #1;
        check_output();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        logic [6:0]  ops [9];
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        i = $urandom;
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        i[11:7]  = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 10);
        if (k < 9) i[6:0] = ops[k];
        else i[6:0] = 7'($urandom);
        case ($urandom_range(0, 3))
            0: i[31:25] = 7'h00;
            1: i[31:25] = 7'h20;
            default: ;
        endcase
        return i;
    endfunction

    initial begin
        logic rdy;
        reset = 1'b0;
        if_valid = 0; if_instruction = 0; if_pc = 0;
        wb_register_write = 0; wb_write_register = 0; wb_write_data = 0;
        flush = 0; ex_ready = 1;
        pend_we = 0; pend_rd = 0; pend_data = 0;
        m = '0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'd0; rf[1] = 32'h1111; rf[2] = 32'h2222;
        rf[5] = 32'd7; rf[6] = 32'h66;

        repeat (2) @(posedge clock);
        #1;
        check("reset id_valid", 32'(id_valid), 32'd0);
        check("reset id_illegal", 32'(id_illegal), 32'd0);
        check("reset id_pc", id_pc, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // ADDI x1,x5,-3 reads x5=7.
        apply_stimulus(1, 32'hFFD28093, 32'h100, 0, 0, 0, 0, 1, rdy);
        check("addi ready", 32'(rdy), 32'd1);
        check("addi valid", 32'(id_valid), 32'd1);
        check("addi rs1_data", id_rs1_data, 32'd7);
        check("addi imm", id_immediate, 32'hFFFFFFFD);
        check("addi alu_op", 32'(id_alu_op), 32'd0);
        check("addi src_imm", 32'(id_alu_src_imm), 32'd1);
        check("addi rd", 32'(id_rd), 32'd1);

        // ADD x3,x1,x2 while write-back is writing x1=0x55.
        apply_stimulus(1, 32'h002081B3, 32'h104, 1, 5'd1, 32'h55, 0, 1, rdy);
        check("bypass rs1_data", id_rs1_data, 32'h55);
        check("bypass rs2_data", id_rs2_data, 32'h2222);

        // LW x6,0(x2) followed by dependent ADD x7,x6,x1.
        apply_stimulus(1, 32'h00012303, 32'h108, 0, 0, 0, 0, 1, rdy);
        check("lw mem_read", 32'(id_mem_read), 32'd1);
        apply_stimulus(1, 32'h001303B3, 32'h10C, 0, 0, 0, 0, 1, rdy);
        check("load-use ready", 32'(rdy), 32'd0);
        check("load-use bubble", 32'(id_valid), 32'd0);
        apply_stimulus(1, 32'h001303B3, 32'h10C, 0, 0, 0, 0, 1, rdy);
        check("after bubble ready", 32'(rdy), 32'd1);
        check("after bubble valid", 32'(id_valid), 32'd1);
        check("after bubble rs1", 32'(id_rs1), 32'd6);
        check("after bubble rs1_data", id_rs1_data, 32'h66);
        check("after bubble rs2_data", id_rs2_data, 32'h55);

        // SW x5,8(x2) held under backpressure.
        apply_stimulus(1, 32'h00512423, 32'h110, 0, 0, 0, 0, 1, rdy);
        check("sw imm", id_immediate, 32'd8);
        for (int n = 0; n < 3; n++) begin
            apply_stimulus(1, 32'h00500093, 32'h114, 0, 0, 0, 0, 0, rdy);
            check("stall ready", 32'(rdy), 32'd0);
            check("stall pc", id_pc, 32'h110);
            check("stall mem_write", 32'(id_mem_write), 32'd1);
        end
        apply_stimulus(1, 32'h00500093, 32'h114, 0, 0, 0, 0, 1, rdy);
        check("release ready", 32'(rdy), 32'd1);
        check("release pc", id_pc, 32'h114);

        // BEQ x1,x2,+8 held, then flushed while ADDI is presented.
        apply_stimulus(1, 32'h00208463, 32'h118, 0, 0, 0, 0, 1, rdy);
        check("beq imm", id_immediate, 32'd8);
        check("beq branch", 32'(id_branch), 32'd1);
        check("beq alu_op", 32'(id_alu_op), 32'd1);
        apply_stimulus(1, 32'h00500093, 32'h11C, 0, 0, 0, 1, 0, rdy);
        check("flush ready", 32'(rdy), 32'd1);
        check("flush valid", 32'(id_valid), 32'd0);
        apply_stimulus(0, 32'h00000013, 32'h120, 0, 0, 0, 0, 1, rdy);
        check("flush dropped", 32'(id_valid), 32'd0);

        // Illegal encodings.
        apply_stimulus(1, 32'h0000007F, 32'h124, 0, 0, 0, 0, 1, rdy);
        check("op7f illegal", 32'(id_illegal), 32'd1);
        check("op7f writes", 32'({id_register_write, id_mem_read, id_mem_write, id_branch, id_jump}), 32'd0);
        apply_stimulus(1, 32'h40109093, 32'h128, 0, 0, 0, 0, 1, rdy);
        check("slli illegal", 32'(id_illegal), 32'd1);
        check("slli valid", 32'(id_valid), 32'd1);
        check("slli writes", 32'({id_register_write, id_mem_read, id_mem_write, id_branch, id_jump}), 32'd0);

        // Randomized traffic over a small register set to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            apply_stimulus($urandom_range(0, 9) < 8, rand_instr(), $urandom,
                           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, rdy);
        end

        // Asynchronous reset between edges.
        apply_stimulus(1, 32'h00500093, 32'h200, 0, 0, 0, 0, 1, rdy);
        check("pre-reset valid", 32'(id_valid), 32'd1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("async id_valid", 32'(id_valid), 32'd0);
        check("async id_pc", id_pc, 32'd0);
        check("async id_immediate", id_immediate, 32'd0);
        check("async id_rs1_data", id_rs1_data, 32'd0);
        check("async id_register_write", 32'(id_register_write), 32'd0);
        check("async id_illegal", 32'(id_illegal), 32'd0);
        m = '0;
        @(negedge clock);
        reset = 1'b1;
        apply_stimulus(0, 32'h0, 32'h0, 0, 0, 0, 0, 1, rdy);
        check("post-reset ready", 32'(rdy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
